// File: rtl/quad_enc_pkg.sv
// Shared types for the quadrature encoder emulator: phase encoding, channel
// FSM states and the command record handed from the decoder to each channel.
package quad_enc_pkg;

    localparam int unsigned CMD_CNT_W = 32;
    localparam int unsigned CMD_PRD_W = 32;

    typedef logic [1:0] phase_t;   // {A, B}

    typedef enum logic {
        IDLE,
        RUN
    } ch_state_t;

    // Fields are sized for the widest supported build; channels use the low bits.
    typedef struct packed {
        logic                 ccw;
        logic [CMD_CNT_W-1:0] steps;
        logic [CMD_PRD_W-1:0] qprd;
    } enc_cmd_t;

    function automatic phase_t next_phase(input phase_t ph, input logic ccw);
        phase_t nxt;
        if (!ccw) begin
            case (ph)
                2'b00:   nxt = 2'b10;
                2'b10:   nxt = 2'b11;
                2'b11:   nxt = 2'b01;
                default: nxt = 2'b00;
            endcase
        end else begin
            case (ph)
                2'b00:   nxt = 2'b01;
                2'b01:   nxt = 2'b11;
                2'b11:   nxt = 2'b10;
                default: nxt = 2'b00;
            endcase
        end
        return nxt;
    endfunction

endpackage

// File: rtl/quad_enc_ch.sv
// One encoder channel: command latch, edge-spacing timer, step counter,
// phase register and signed position counter.
module quad_enc_ch
    import quad_enc_pkg::*;
#(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned PRD_W = 16,
    parameter int unsigned POS_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  enc_cmd_t         cmd,
    output phase_t           phase,
    output logic             busy,
    output logic             done,
    output logic [POS_W-1:0] pos
);

    ch_state_t        state_q, state_d;
    phase_t           phase_q, phase_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [CNT_W-1:0] steps_q, steps_d;
    logic [PRD_W-1:0] timer_q, timer_d;
    logic [PRD_W-1:0] qprd_q, qprd_d;
    logic [PRD_W-1:0] qprd_in;
    logic             ccw_q, ccw_d;
    logic             cont_q, cont_d;
    logic             done_q, done_d;
    logic             unused_cmd;

    assign unused_cmd = ^cmd;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        pos_d   = pos_q;
        steps_d = steps_q;
        timer_d = timer_q;
        qprd_d  = qprd_q;
        ccw_d   = ccw_q;
        cont_d  = cont_q;
        done_d  = 1'b0;
        qprd_in = cmd.qprd[PRD_W-1:0];
        if (qprd_in == '0) begin
            qprd_in = PRD_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    ccw_d   = cmd.ccw;
                    steps_d = cmd.steps[CNT_W-1:0];
                    cont_d  = (cmd.steps[CNT_W-1:0] == '0);
                    qprd_d  = qprd_in;
                    timer_d = qprd_in - PRD_W'(1);
                    state_d = RUN;
                end
            end
            RUN: begin
                // Abort outranks an edge scheduled for the same cycle.
                if (abort) begin
                    state_d = IDLE;
                end else if (timer_q == '0) begin
                    phase_d = next_phase(phase_q, ccw_q);
                    pos_d   = ccw_q ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
                    timer_d = qprd_q - PRD_W'(1);
                    if (!cont_q) begin
                        steps_d = steps_q - CNT_W'(1);
                        if (steps_q == CNT_W'(1)) begin
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    timer_d = timer_q - PRD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            phase_q <= '0;
            pos_q   <= '0;
            steps_q <= '0;
            timer_q <= '0;
            qprd_q  <= '0;
            ccw_q   <= 1'b0;
            cont_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            pos_q   <= pos_d;
            steps_q <= steps_d;
            timer_q <= timer_d;
            qprd_q  <= qprd_d;
            ccw_q   <= ccw_d;
            cont_q  <= cont_d;
            done_q  <= done_d;
        end
    end

    assign phase = phase_q;
    assign busy  = (state_q == RUN);
    assign done  = done_q;
    assign pos   = pos_q;

endmodule

// File: rtl/quad_enc_gen.sv
// Multi-channel quadrature encoder emulator: decodes the shared command port,
// applies per-channel back-pressure and fans out to CH independent channels.
module quad_enc_gen
    import quad_enc_pkg::*;
#(
    parameter  int unsigned CH    = 2,
    parameter  int unsigned CNT_W = 16,
    parameter  int unsigned PRD_W = 16,
    parameter  int unsigned POS_W = 32,
    localparam int unsigned CH_W  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [CH_W-1:0]       cmd_ch,
    input  logic                  cmd_abort,
    input  logic                  cmd_ccw,
    input  logic [CNT_W-1:0]      cmd_steps,
    input  logic [PRD_W-1:0]      cmd_qprd,
    output logic [CH-1:0]         enc_a,
    output logic [CH-1:0]         enc_b,
    output logic [CH-1:0]         busy,
    output logic [CH-1:0]         done,
    output logic [CH*POS_W-1:0]   pos
);

    logic     ch_ok;
    logic     busy_sel;
    logic     accept;
    enc_cmd_t cmd_s;

    always_comb begin
        busy_sel = 1'b0;
        for (int unsigned i = 0; i < CH; i++) begin
            if (cmd_ch == CH_W'(i)) begin
                busy_sel = busy[i];
            end
        end
    end

    // Out-of-range channels are accepted so a stray command cannot wedge the port.
    assign ch_ok     = ({1'b0, cmd_ch} < (CH_W + 1)'(CH));
    assign cmd_ready = !ch_ok || cmd_abort || !busy_sel;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        cmd_s       = '0;
        cmd_s.ccw   = cmd_ccw;
        cmd_s.steps = CMD_CNT_W'(cmd_steps);
        cmd_s.qprd  = CMD_PRD_W'(cmd_qprd);
    end

    for (genvar g = 0; g < CH; g++) begin : g_ch
        phase_t phase;
        logic   sel;

        assign sel = accept && ch_ok && (cmd_ch == CH_W'(g));

        quad_enc_ch #(
            .CNT_W (CNT_W),
            .PRD_W (PRD_W),
            .POS_W (POS_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .start (sel && !cmd_abort),
            .abort (sel && cmd_abort),
            .cmd   (cmd_s),
            .phase (phase),
            .busy  (busy[g]),
            .done  (done[g]),
            .pos   (pos[g*POS_W +: POS_W])
        );

        assign enc_a[g] = phase[1];
        assign enc_b[g] = phase[0];
    end

endmodule
